pkt_gen_bp: RTL

//  Parametrised per-port test-packet generator with downstream backpressure. Successor to the

---
 rtl/pkt_gen_bp_if.sv | 35 +++
 rtl/pkt_gen_bp.sv | 115 +++++++++++
 2 files changed

// File: rtl/pkt_gen_bp_if.sv
// Descriptor and beat-stream signals of one packet-generator port.
// The master modport is the generator; the slave modport is its environment.
interface pkt_gen_bp_if #(
  parameter int DW    = 32,
  parameter int DA_W  = 4,
  parameter int PRI_W = 3,
  parameter int LEN_W = 10,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16
);
  logic             i_desc_vld;
  logic             o_desc_rdy;
  logic [DA_W-1:0]  i_desc_da;
  logic [PRI_W-1:0] i_desc_prior;
  logic [LEN_W-1:0] i_desc_len;
  logic [GAP_W-1:0] i_gap;
  logic [1:0]       i_mode;
  logic             i_ready;
  logic             o_sop;
  logic             o_vld;
  logic [DW-1:0]    o_data;
  logic             o_eop;
  logic             o_busy;
  logic [CNT_W-1:0] o_pkt_cnt;

  modport master (
    input  i_desc_vld, i_desc_da, i_desc_prior, i_desc_len, i_gap, i_mode, i_ready,
    output o_desc_rdy, o_sop, o_vld, o_data, o_eop, o_busy, o_pkt_cnt
  );

  modport slave (
    output i_desc_vld, i_desc_da, i_desc_prior, i_desc_len, i_gap, i_mode, i_ready,
    input  o_desc_rdy, o_sop, o_vld, o_data, o_eop, o_busy, o_pkt_cnt
  );
endinterface

// File: rtl/pkt_gen_bp.sv
// Per-port test-packet generator: one descriptor in, header plus len payload beats out,
// with downstream backpressure, a programmable inter-packet gap and three payload modes.
module pkt_gen_bp #(
  parameter int DW    = 32,
  parameter int DA_W  = 4,
  parameter int PRI_W = 3,
  parameter int LEN_W = 10,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16,
  parameter int ID    = 0
) (
  input logic          clk,
  input logic          rst_n,
  pkt_gen_bp_if.master bus
);

  localparam logic [3:0] PORT_ID = 4'(ID);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [DA_W-1:0]  da_q;
  logic [PRI_W-1:0] pri_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [GAP_W-1:0] gap_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_snap_q;
  logic [CNT_W-1:0] pkt_cnt_q;

  logic             desc_rdy, accept, vld, sop, eop, xfer, last_pay;
  logic [LEN_W-1:0] beat_num;
  logic [DW-1:0]    hdr_word, pay_word, data;

  // Gated by rst_n so every output, ready included, reads 0 while reset is held.
  assign desc_rdy = (state_q == S_IDLE) & rst_n;
  assign accept   = bus.i_desc_vld & desc_rdy;
  assign vld      = (state_q == S_HDR) || (state_q == S_PAY);
  assign sop      = (state_q == S_HDR);
  assign last_pay = (idx_q == len_q - LEN_W'(1));
  assign eop      = ((state_q == S_HDR) && (len_q == '0)) || ((state_q == S_PAY) && last_pay);
  assign xfer     = vld & bus.i_ready;
  assign beat_num = idx_q + LEN_W'(1);
  assign hdr_word = DW'({PORT_ID, da_q, pri_q, len_q});

  always_comb begin
    // NOTE: default first so no path through the case leaves pay_word unassigned (no latch).
    pay_word = DW'(beat_num);
    case (mode_q)
      2'd1:    pay_word = DW'(cnt_snap_q);
      2'd2:    pay_word = ~DW'(beat_num);
      default: pay_word = DW'(beat_num);
    endcase
  end

  assign data = (state_q == S_HDR) ? hdr_word :
                (state_q == S_PAY) ? pay_word : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_HDR;
      S_HDR: begin
        if (xfer) begin
          if (len_q != '0)      state_d = S_PAY;
          else if (gap_q != '0) state_d = S_GAP;
          else                  state_d = S_IDLE;
        end
      end
      S_PAY: if (xfer && last_pay) state_d = (gap_q != '0) ? S_GAP : S_IDLE;
      // gap_q counts down once per GAP cycle, so a load of N gives exactly N idle cycles.
      S_GAP: if (gap_q == GAP_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      da_q       <= '0;
      pri_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      mode_q     <= '0;
      cnt_snap_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        da_q       <= bus.i_desc_da;
        pri_q      <= bus.i_desc_prior;
        len_q      <= bus.i_desc_len;
        gap_q      <= bus.i_gap;
        mode_q     <= bus.i_mode;
        idx_q      <= '0;
        cnt_snap_q <= pkt_cnt_q;
      end else if ((state_q == S_PAY) && xfer && !last_pay) begin
        idx_q <= idx_q + LEN_W'(1);
      end
      if (state_q == S_GAP) gap_q <= gap_q - GAP_W'(1);
      if (xfer && eop) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_desc_rdy = desc_rdy;
  assign bus.o_vld      = vld;
  assign bus.o_sop      = sop;
  assign bus.o_eop      = eop;
  assign bus.o_data     = data;
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_pkt_cnt  = pkt_cnt_q;

endmodule
